multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/multi_cycle_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-subset control unit: Moore FSM driving datapath strobes and mux selects.
// Opcode/func are captured when leaving ID so later states ignore IR changes.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       memRead,
  output logic       memWrite,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       wRsel,
  output logic       jalSel,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [2:0] operation,
  output logic [3:0] state,
  output logic       instrDone
);

  localparam int unsigned StateW = 4;
  localparam int unsigned OpW    = 6;
  localparam int unsigned AluW   = 3;

  localparam logic [OpW-1:0] opRtype = 6'b000000;
  localparam logic [OpW-1:0] opLw    = 6'b100011;
  localparam logic [OpW-1:0] opSw    = 6'b101011;
  localparam logic [OpW-1:0] opBeq   = 6'b000100;
  localparam logic [OpW-1:0] opAddi  = 6'b001000;
  localparam logic [OpW-1:0] opSlti  = 6'b001010;
  localparam logic [OpW-1:0] opJ     = 6'b000010;
  localparam logic [OpW-1:0] opJal   = 6'b000011;
  localparam logic [OpW-1:0] fnJr    = 6'b001000;

  localparam logic [AluW-1:0] aluAnd = 3'b000;
  localparam logic [AluW-1:0] aluOr  = 3'b001;
  localparam logic [AluW-1:0] aluAdd = 3'b010;
  localparam logic [AluW-1:0] aluSub = 3'b110;
  localparam logic [AluW-1:0] aluSlt = 3'b111;

  typedef enum logic [StateW-1:0] {
    sIf    = 4'd0,
    sId    = 4'd1,
    sMadr  = 4'd2,
    sLwMem = 4'd3,
    sLwWb  = 4'd4,
    sSwMem = 4'd5,
    sRex   = 4'd6,
    sRwb   = 4'd7,
    sBeq   = 4'd8,
    sIex   = 4'd9,
    sIwb   = 4'd10,
    sJ     = 4'd11,
    sJal   = 4'd12,
    sJr    = 4'd13
  } stateT;

  stateT           curState;
  stateT           nextState;
  logic [OpW-1:0]  opReg;
  logic [OpW-1:0]  funcReg;
  logic [AluW-1:0] rAluOp;
  logic            rLegal;

  // The datapath already gates zero with pcWriteCond.
  logic unusedZero;
  assign unusedZero = zero;

  assign state = curState;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState <= sIf;
    end else begin
      curState <= nextState;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opReg   <= '0;
      funcReg <= '0;
    end else if (curState == sId) begin
      opReg   <= opcode;
      funcReg <= func;
    end
  end

  // R-type function decode; unknown functions add but never write back.
  always_comb begin
    rAluOp = aluAdd;
    rLegal = 1'b1;
    case (funcReg)
      6'b100000: rAluOp = aluAdd;
      6'b100010: rAluOp = aluSub;
      6'b100100: rAluOp = aluAnd;
      6'b100101: rAluOp = aluOr;
      6'b101010: rAluOp = aluSlt;
      default:   rLegal = 1'b0;
    endcase
  end

  always_comb begin
    nextState   = sIf;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    wRsel       = 1'b0;
    jalSel      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSrc       = 2'b00;
    operation   = aluAnd;
    instrDone   = 1'b0;
    case (curState)
      sIf: begin
        memRead   = 1'b1;
        IRWrite   = 1'b1;
        aluSrcB   = 2'b01;
        operation = aluAdd;
        pcWrite   = 1'b1;
        nextState = sId;
      end
      sId: begin
        aluSrcB   = 2'b11;
        operation = aluAdd;
        case (opcode)
          opLw, opSw:    nextState = sMadr;
          opRtype:       nextState = (func == fnJr) ? sJr : sRex;
          opBeq:         nextState = sBeq;
          opAddi, opSlti: nextState = sIex;
          opJ:           nextState = sJ;
          opJal:         nextState = sJal;
          default:       nextState = sIf;
        endcase
      end
      sMadr: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        operation = aluAdd;
        nextState = (opReg == opLw) ? sLwMem : sSwMem;
      end
      sLwMem: begin
        memRead   = 1'b1;
        IorD      = 1'b1;
        nextState = sLwWb;
      end
      sLwWb: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      sSwMem: begin
        memWrite  = 1'b1;
        IorD      = 1'b1;
        instrDone = 1'b1;
      end
      sRex: begin
        aluSrcA   = 1'b1;
        operation = rAluOp;
        nextState = sRwb;
      end
      sRwb: begin
        regDst    = 1'b1;
        regWrite  = rLegal;
        instrDone = 1'b1;
      end
      sBeq: begin
        aluSrcA     = 1'b1;
        operation   = aluSub;
        pcWriteCond = 1'b1;
        pcSrc       = 2'b10;
        instrDone   = 1'b1;
      end
      sIex: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        operation = (opReg == opSlti) ? aluSlt : aluAdd;
        nextState = sIwb;
      end
      sIwb: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      sJ: begin
        pcWrite   = 1'b1;
        pcSrc     = 2'b01;
        instrDone = 1'b1;
      end
      sJal: begin
        pcWrite   = 1'b1;
        pcSrc     = 2'b01;
        wRsel     = 1'b1;
        jalSel    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      sJr: begin
        pcWrite   = 1'b1;
        pcSrc     = 2'b11;
        instrDone = 1'b1;
      end
      default: nextState = sIf;
    endcase
    // Reset holds the IF selects but silences every strobe.
    if (!rst) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      IRWrite     = 1'b0;
      regWrite    = 1'b0;
      memWrite    = 1'b0;
      memRead     = 1'b0;
      instrDone   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: instruction table, random instruction stream
// against a per-instruction control-sequence model, and reset corner cases.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       memRead, memWrite, pcWrite, pcWriteCond, IorD, IRWrite;
  logic       regDst, memToReg, wRsel, jalSel, regWrite, aluSrcA, instrDone;
  logic [1:0] aluSrcB, pcSrc;
  logic [2:0] operation;
  logic [3:0] state;

  int nTests = 0;
  int nFail  = 0;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .memRead(memRead), .memWrite(memWrite), .pcWrite(pcWrite),
    .pcWriteCond(pcWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .regDst(regDst), .memToReg(memToReg), .wRsel(wRsel), .jalSel(jalSel),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc),
    .operation(operation), .state(state), .instrDone(instrDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic memRead, memWrite, pcWrite, pcWriteCond, IorD, IRWrite;
    logic regDst, memToReg, wRsel, jalSel, regWrite, aluSrcA, instrDone;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [2:0] operation;
  } ctrlT;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         lat;
    int         done;
    int         wr;
    int         mw;
  } vecT;

  ctrlT expQ[$];

  function automatic ctrlT dutVec();
    ctrlT c;
    c.st = state; c.memRead = memRead; c.memWrite = memWrite; c.pcWrite = pcWrite;
    c.pcWriteCond = pcWriteCond; c.IorD = IorD; c.IRWrite = IRWrite; c.regDst = regDst;
    c.memToReg = memToReg; c.wRsel = wRsel; c.jalSel = jalSel; c.regWrite = regWrite;
    c.aluSrcA = aluSrcA; c.instrDone = instrDone; c.aluSrcB = aluSrcB; c.pcSrc = pcSrc;
    c.operation = operation;
    return c;
  endfunction

  function automatic ctrlT base(input int st);
    ctrlT c;
    c = '0;
    c.st = 4'(st);
    return c;
  endfunction

  function automatic ctrlT rstVec();
    ctrlT c;
    c = base(0);
    c.aluSrcB = 2'b01;
    c.operation = 3'b010;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected control word for every cycle of one instruction, IF through its last state.
  task automatic buildModel(input logic [5:0] op, input logic [5:0] fn);
    ctrlT c;
    logic [2:0] rOp;
    logic legal;
    expQ.delete();
    c = base(0); c.memRead = 1; c.IRWrite = 1; c.pcWrite = 1; c.aluSrcB = 2'b01;
    c.operation = 3'b010; expQ.push_back(c);
    c = base(1); c.aluSrcB = 2'b11; c.operation = 3'b010; expQ.push_back(c);
    if (op == 6'd35 || op == 6'd43) begin
      c = base(2); c.aluSrcA = 1; c.aluSrcB = 2'b10; c.operation = 3'b010; expQ.push_back(c);
      if (op == 6'd35) begin
        c = base(3); c.memRead = 1; c.IorD = 1; expQ.push_back(c);
        c = base(4); c.memToReg = 1; c.regWrite = 1; c.instrDone = 1; expQ.push_back(c);
      end else begin
        c = base(5); c.memWrite = 1; c.IorD = 1; c.instrDone = 1; expQ.push_back(c);
      end
    end else if (op == 6'd0 && fn == 6'b001000) begin
      c = base(13); c.pcWrite = 1; c.pcSrc = 2'b11; c.instrDone = 1; expQ.push_back(c);
    end else if (op == 6'd0) begin
      legal = 1'b1;
      case (fn)
        6'b100000: rOp = 3'b010;
        6'b100010: rOp = 3'b110;
        6'b100100: rOp = 3'b000;
        6'b100101: rOp = 3'b001;
        6'b101010: rOp = 3'b111;
        default: begin rOp = 3'b010; legal = 1'b0; end
      endcase
      c = base(6); c.aluSrcA = 1; c.operation = rOp; expQ.push_back(c);
      c = base(7); c.regDst = 1; c.regWrite = legal; c.instrDone = 1; expQ.push_back(c);
    end else if (op == 6'd4) begin
      c = base(8); c.aluSrcA = 1; c.operation = 3'b110; c.pcWriteCond = 1; c.pcSrc = 2'b10;
      c.instrDone = 1; expQ.push_back(c);
    end else if (op == 6'd8 || op == 6'd10) begin
      c = base(9); c.aluSrcA = 1; c.aluSrcB = 2'b10;
      c.operation = (op == 6'd10) ? 3'b111 : 3'b010; expQ.push_back(c);
      c = base(10); c.regWrite = 1; c.instrDone = 1; expQ.push_back(c);
    end else if (op == 6'd2) begin
      c = base(11); c.pcWrite = 1; c.pcSrc = 2'b01; c.instrDone = 1; expQ.push_back(c);
    end else if (op == 6'd3) begin
      c = base(12); c.pcWrite = 1; c.pcSrc = 2'b01; c.wRsel = 1; c.jalSel = 1;
      c.regWrite = 1; c.instrDone = 1; expQ.push_back(c);
    end
  endtask

  // Runs one instruction starting in IF; IR bits are scrambled once the ID edge has passed.
  task automatic runInstr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          output int lat, output int doneCnt, output int wrCnt, output int mwCnt);
    buildModel(op, fn);
    lat = 1; doneCnt = 0; wrCnt = 0; mwCnt = 0;
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, i), 32'(dutVec()), 32'(expQ[i]));
      if (i > 0 && state != 4'd0) lat++;
      doneCnt += int'(instrDone);
      wrCnt   += int'(regWrite);
      mwCnt   += int'(memWrite);
      zero = 1'($urandom);
      if (i == 0) begin
        opcode = op;
        func   = fn;
      end else if (i >= 1 && i + 1 < expQ.size() + 1 && i != 1) begin
        opcode = 6'($urandom);
        func   = 6'($urandom);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecT tbl[13];
    logic [5:0] opOpts[10];
    logic [5:0] fnOpts[7];
    int lat, dn, wr, mw;
    logic [5:0] op, fn;

    tbl[0]  = '{"lw",    6'b100011, 6'b000000, 5, 1, 1, 0};
    tbl[1]  = '{"sw",    6'b101011, 6'b000000, 4, 1, 0, 1};
    tbl[2]  = '{"add",   6'b000000, 6'b100000, 4, 1, 1, 0};
    tbl[3]  = '{"sub",   6'b000000, 6'b100010, 4, 1, 1, 0};
    tbl[4]  = '{"slt",   6'b000000, 6'b101010, 4, 1, 1, 0};
    tbl[5]  = '{"rbad",  6'b000000, 6'b000111, 4, 1, 0, 0};
    tbl[6]  = '{"jr",    6'b000000, 6'b001000, 3, 1, 0, 0};
    tbl[7]  = '{"beq",   6'b000100, 6'b000000, 3, 1, 0, 0};
    tbl[8]  = '{"addi",  6'b001000, 6'b000000, 4, 1, 1, 0};
    tbl[9]  = '{"slti",  6'b001010, 6'b000000, 4, 1, 1, 0};
    tbl[10] = '{"j",     6'b000010, 6'b000000, 3, 1, 0, 0};
    tbl[11] = '{"jal",   6'b000011, 6'b000000, 3, 1, 1, 0};
    tbl[12] = '{"illeg", 6'b111111, 6'b000000, 2, 0, 0, 0};

    opOpts = '{6'd35, 6'd43, 6'd0, 6'd0, 6'd4, 6'd8, 6'd10, 6'd2, 6'd3, 6'd0};
    fnOpts = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000, 6'b000000};

    // Reset state with strobes silenced.
    #2;
    check("reset", 32'(dutVec()), 32'(rstVec()));
    @(posedge clk); #1;
    check("reset held", 32'(dutVec()), 32'(rstVec()));
    rst = 1'b1;

    foreach (tbl[k]) begin
      runInstr(tbl[k].name, tbl[k].op, tbl[k].fn, lat, dn, wr, mw);
      check({tbl[k].name, " latency"}, 32'(lat), 32'(tbl[k].lat));
      check({tbl[k].name, " doneCnt"}, 32'(dn), 32'(tbl[k].done));
      check({tbl[k].name, " regWrCnt"}, 32'(wr), 32'(tbl[k].wr));
      check({tbl[k].name, " memWrCnt"}, 32'(mw), 32'(tbl[k].mw));
    end

    for (int n = 0; n < 60; n++) begin
      op = opOpts[$urandom_range(0, 9)];
      fn = fnOpts[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      runInstr($sformatf("rnd%0d op%b fn%b", n, op, fn), op, fn, lat, dn, wr, mw);
    end

    // Reset asserted while lw sits in LWMEM.
    buildModel(6'b100011, 6'b000000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lwrst cyc%0d", i), 32'(dutVec()), 32'(expQ[i]));
      if (i == 0) begin opcode = 6'b100011; func = 6'b000000; end
      if (i >= 2) begin opcode = 6'($urandom); func = 6'($urandom); end
    end
    #2 rst = 1'b0;
    #1;
    check("async reset in LWMEM", 32'(dutVec()), 32'(rstVec()));
    @(negedge clk);
    check("reset hold after LWMEM", 32'(dutVec()), 32'(rstVec()));
    @(posedge clk); #1;
    rst = 1'b1;
    runInstr("beq after reset", 6'b000100, 6'b000000, lat, dn, wr, mw);
    check("beq after reset latency", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
